sumador_serie: RTL

//  Bit-serial N-bit adder: adds A+B+Cin LSB-first, one bit per clock.

---
 rtl/sumador_serie_pkg.sv | 24 ++
 rtl/sumador_serie_if.sv | 47 ++++
 rtl/sumador_serie_completo.sv | 39 +++
 rtl/sumador_serie_medio.sv | 21 ++
 rtl/sumador_serie.sv | 123 ++++++++++++
 5 files changed

// File: rtl/sumador_serie_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : sumador_pkg                                                |
// | Shared definitions for the bit-serial adder: the default operand     |
// | width and the FSM state encoding.                                    |
// | Optional feature macro used by this slice: SUMADOR_OVF_EN            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package sumador_pkg;

  localparam int N_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUMA = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SUMA = ST_SUMA,
    FIN  = ST_FIN
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sumador_serie_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : sumador_serie_if                                         |
// | Start/busy/done handshake and operand/result bus of the serial adder.|
// |   start, A, B, Cin : requester -> adder                              |
// |   busy, done       : adder status                                    |
// |   suma, Cout       : result, held until the next accepted start      |
// |   ovf              : signed overflow, present only with              |
// |                      SUMADOR_OVF_EN                                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface sumador_serie_if
  import sumador_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] suma;
  logic         Cout;
`ifdef SUMADOR_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, A, B, Cin,
    input  busy, done, suma, Cout
`ifdef SUMADOR_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, suma, Cout
`ifdef SUMADOR_OVF_EN
    , output ovf
`endif
  );

endinterface
`default_nettype wire

// File: rtl/sumador_serie_completo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sumador_completo                                            |
// | One-bit full adder built from two half adders; the two partial       |
// | carries can never both be set, so an OR merges them.                 |
// |   a, b, cin : input bits                                             |
// |   s, cout   : sum and carry-out                                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sumador_completo (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  sumador_medio u_ha0 (
    .a    (a),
    .b    (b),
    .suma (w_s1),
    .cout (w_c1)
  );

  sumador_medio u_ha1 (
    .a    (w_s1),
    .b    (cin),
    .suma (s),
    .cout (w_c2)
  );

  assign cout = w_c1 | w_c2;

endmodule
`default_nettype wire

// File: rtl/sumador_serie_medio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sumador_medio                                               |
// | One-bit half adder.                                                  |
// |   a, b : input bits                                                  |
// |   suma : a XOR b                                                     |
// |   cout : a AND b                                                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sumador_medio (
  input  wire logic a,
  input  wire logic b,
  output logic      suma,
  output logic      cout
);

  assign suma = a ^ b;
  assign cout = a & b;

endmodule
`default_nettype wire

// File: rtl/sumador_serie.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sumador_serie                                               |
// | Bit-serial N-bit adder computing A+B+Cin LSB-first, one bit per      |
// | clock, through a single reused full adder.                           |
// |   clk  : rising-edge clock                                           |
// |   rst  : asynchronous active-high reset                              |
// |   bus  : sumador_serie_if.slave (start/A/B/Cin in,                   |
// |          busy/done/suma/Cout[/ovf] out)                              |
// | Optional: define SUMADOR_OVF_EN to add the signed-overflow output.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  wire logic      clk,
  input  wire logic      rst,
  sumador_serie_if.slave bus
);

  // One extra bit so the step counter can reach N without wrapping.
  localparam int            CW     = $clog2(N) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  state_t        r_state;
  logic [N-1:0]  r_ra;
  logic [N-1:0]  r_rb;
  logic [N-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_suma;
  logic          r_cout;
`ifdef SUMADOR_OVF_EN
  logic          r_ovf;
`endif

  logic          w_s;
  logic          w_c;
  logic [N-1:0]  w_res_nxt;

  sumador_completo u_fa (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // New sum bit enters at the MSB; after N steps bit 0 holds the first sum bit.
  assign w_res_nxt = (r_res >> 1) | ({{(N-1){1'b0}}, w_s} << (N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_suma  <= '0;
      r_cout  <= 1'b0;
`ifdef SUMADOR_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ra    <= bus.A;
            r_rb    <= bus.B;
            r_carry <= bus.Cin;
            r_res   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SUMA;
          end
        end
        SUMA: begin
          r_ra    <= r_ra >> 1;
          r_rb    <= r_rb >> 1;
          r_res   <= w_res_nxt;
          r_carry <= w_c;
          r_count <= r_count + 1'b1;
          if (r_count == C_LAST) begin
            // Results are published on FIN entry so done and suma align.
            r_suma  <= w_res_nxt;
            r_cout  <= w_c;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
`ifdef SUMADOR_OVF_EN
            // Carry into the MSB differs from carry out of it on signed overflow.
            r_ovf   <= r_carry ^ w_c;
`endif
            r_state <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.suma = r_suma;
  assign bus.Cout = r_cout;
`ifdef SUMADOR_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
